register_array_kv: RTL
======================

// Module: register_array_kv
// PURPOSE
//  Parametrised successor priority queue: sorted register array of (key, value) entries, one op per cycle.
//  Adds payload, selectable min/max ordering, stable FIFO order among equal keys, occupancy count,
//  optional evict-on-full and error/drop pulses. Sits beside the heap/tree queues as the low-depth,
//  single-cycle-update baseline in the hwpq comparison set.
// PARAMETERS
//  QUEUE_SIZE    64  number of entry slots (>=2)
//  KEY_WIDTH     16  priority key width, unsigned
//  VAL_WIDTH     16  payload width carried with each key
//  MAX_FIRST     1   1: largest key at top; 0: smallest key at top
//  EVICT_ON_FULL 0   1: enqueue when full may evict the worst entry; 0: enqueue when full is dropped
// PORTS
//  CLK      in   1                     clock, all state updates on rising edge
//  RST      in   1                     synchronous reset, active-high
//  i_wrt    in   1                     enqueue request (with i_read: replace)
//  i_read   in   1                     dequeue request (with i_wrt: replace)
//  i_key    in   KEY_WIDTH             key to insert
//  i_val    in   VAL_WIDTH             payload to insert
//  o_full   out  1                     count == QUEUE_SIZE
//  o_empty  out  1                     count == 0
//  o_key    out  KEY_WIDTH             key of top entry; 0 when empty
//  o_val    out  VAL_WIDTH             payload of top entry; 0 when empty
//  o_count  out  $clog2(QUEUE_SIZE+1)  current occupancy
//  o_drop   out  1                     1-cycle pulse: insert discarded or entry evicted
//  o_err    out  1                     1-cycle pulse: dequeue on empty
// BEHAVIOUR
//  - Reset (RST high at edge): all slots cleared, count=0, o_empty=1, o_full=0, o_key/o_val=0, pulses=0.
//    RST wins over any simultaneous request; an op in flight at that edge is discarded.
//  - Slot 0 holds the top; slots [0..count-1] always sorted; slots >= count hold zero.
//  - "Better" = greater key (MAX_FIRST=1) or smaller key (MAX_FIRST=0). Equal keys: earlier insert ranks higher.
//  - All outputs registered; result of an op visible the cycle after the edge that samples it. No stalls.
//  - Ops decoded from {i_wrt,i_read} each edge:
//    00 idle: hold.
//    10 enqueue: insert pos p = number of valid entries better-or-equal to i_key; slots <p hold,
//       slot p <= new, slots >p shift down one; count+1.
//       Full, EVICT_ON_FULL=0: no change, o_drop=1.
//       Full, EVICT_ON_FULL=1: if i_key strictly better than last entry, last entry discarded and new
//       inserted, count unchanged, o_drop=1; else new discarded, o_drop=1.
//    01 dequeue: slots shift up one, last valid slot cleared, count-1. Empty: no change, o_err=1.
//    11 replace: top removed and new inserted in same cycle, count unchanged; pos computed over
//       slots 1..count-1. Empty: behaves as enqueue (count becomes 1), no o_err.
//  - o_full/o_empty derived from registered count; must be consistent with o_count every cycle.
// STRUCTURE
//  - hwpq_pkg: op_e enum {OP_IDLE, OP_ENQ, OP_DEQ, OP_REPL} shared with other hwpq queues;
//    entry_t struct template helpers not allowed (widths differ) -> pkg holds enum only.
//  - Sub-module register_array_kv_cell: one slot; inputs own/prev/next entry, new entry, op,
//    local "new goes above me" and "prev says new goes above it" compares; outputs next-state entry.
//    Top level: generate QUEUE_SIZE cells, count register, full/evict decision, output pulses.
// TESTING
//  T1 reset: hold RST 2 cycles -> o_empty=1, o_full=0, o_count=0, o_key=0, o_val=0.
//  T2 MAX_FIRST=1: enq keys 5,9,3 -> o_key=9, o_count=3; deq -> o_key=5; deq,deq -> o_empty=1.
//  T3 ties: enq (7,'hA),(7,'hB),(8,'hC) -> deq order vals C,A,B.
//  T4 QUEUE_SIZE=4: fill 10,20,30,40; enq 5 -> o_drop=1, top 40, count 4 (EVICT=0);
//     EVICT=1 enq 50 -> o_drop=1, top 50, remaining deq order 50,40,30,20.
//  T5 replace: queue 40,30,20 -> repl key 1 -> o_key=30, count 3; repl on empty with 6 -> o_key=6, count 1.
//  T6 errors/reset: deq on empty -> o_err=1 one cycle, state unchanged; enq 3 items, RST with i_wrt=1
//     -> empty next cycle; MAX_FIRST=0 random 500-op mix vs sorted model, top/count checked each cycle.

Source files
------------

// File: rtl/hwpq_pkg.sv
// Operation codes shared by the hwpq priority-queue family.
package hwpq_pkg;

   typedef enum logic [1:0] {OP_IDLE, OP_ENQ, OP_DEQ, OP_REPL} op_e;

endpackage

// File: rtl/register_array_kv_cell.sv
// One slot of the sorted register array: selects its next (key, value) from own/prev/next/new
// entries using the per-slot "new goes above" compares.
module register_array_kv_cell
   import hwpq_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 16,
   parameter int unsigned VAL_WIDTH = 16,
   parameter bit          FIRST     = 1'b0
) (
   input  logic [KEY_WIDTH-1:0] own_key,
   input  logic [VAL_WIDTH-1:0] own_val,
   input  logic [KEY_WIDTH-1:0] prev_key,
   input  logic [VAL_WIDTH-1:0] prev_val,
   input  logic [KEY_WIDTH-1:0] next_key,
   input  logic [VAL_WIDTH-1:0] next_val,
   input  logic [KEY_WIDTH-1:0] new_key,
   input  logic [VAL_WIDTH-1:0] new_val,
   input  op_e                  op,
   input  logic                 ge_me,
   input  logic                 ge_prev,
   input  logic                 ge_next,
   output logic [KEY_WIDTH-1:0] key_d,
   output logic [VAL_WIDTH-1:0] val_d
);

   always_comb begin
      key_d = own_key;
      val_d = own_val;
      unique case (op)
         OP_ENQ: begin
            if (ge_me) begin
               key_d = ge_prev ? prev_key : new_key;
               val_d = ge_prev ? prev_val : new_val;
            end
         end
         OP_DEQ: begin
            key_d = next_key;
            val_d = next_val;
         end
         OP_REPL: begin
            // Top is removed, so slot i draws from slot i+1 until the new entry's place.
            if (!ge_next) begin
               key_d = next_key;
               val_d = next_val;
            end else if (!(ge_me && !FIRST)) begin
               key_d = new_key;
               val_d = new_val;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/register_array_kv.sv
// Sorted register-array priority queue of (key, value) entries, one enqueue/dequeue/replace per
// cycle, stable among equal keys, with optional evict-on-full.
module register_array_kv
   import hwpq_pkg::*;
#(
   parameter int unsigned QUEUE_SIZE    = 64,
   parameter int unsigned KEY_WIDTH     = 16,
   parameter int unsigned VAL_WIDTH     = 16,
   parameter bit          MAX_FIRST     = 1'b1,
   parameter bit          EVICT_ON_FULL = 1'b0,
   localparam int unsigned CW           = $clog2(QUEUE_SIZE + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 i_wrt,
   input  logic                 i_read,
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [VAL_WIDTH-1:0] i_val,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [KEY_WIDTH-1:0] o_key,
   output logic [VAL_WIDTH-1:0] o_val,
   output logic [CW-1:0]        o_count,
   output logic                 o_drop,
   output logic                 o_err
);

   logic [KEY_WIDTH-1:0] key_q [QUEUE_SIZE];
   logic [KEY_WIDTH-1:0] key_d [QUEUE_SIZE];
   logic [VAL_WIDTH-1:0] val_q [QUEUE_SIZE];
   logic [VAL_WIDTH-1:0] val_d [QUEUE_SIZE];
   logic [CW-1:0]        count_q, count_d;
   logic                 drop_q, drop_d, err_q, err_d;
   logic                 full, empty;
   logic [QUEUE_SIZE:0]  ge;
   op_e                  op;

   assign full  = (count_q == CW'(QUEUE_SIZE));
   assign empty = (count_q == '0);

   // ge[i]: new entry ranks strictly above slot i (empty slots always yield).
   always_comb begin
      ge = '1;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         ge[i] = !((CW'(i) < count_q) &&
                   (MAX_FIRST ? (key_q[i] >= i_key) : (key_q[i] <= i_key)));
      end
   end

   always_comb begin
      op      = OP_IDLE;
      count_d = count_q;
      drop_d  = 1'b0;
      err_d   = 1'b0;
      case ({i_wrt, i_read})
         2'b10: begin
            if (!full) begin
               op      = OP_ENQ;
               count_d = count_q + CW'(1);
            end else begin
               drop_d = 1'b1;
               // Shifting on a full array pushes the worst entry out of the last slot.
               if (EVICT_ON_FULL && ge[QUEUE_SIZE-1]) op = OP_ENQ;
            end
         end
         2'b01: begin
            if (empty) begin
               err_d = 1'b1;
            end else begin
               op      = OP_DEQ;
               count_d = count_q - CW'(1);
            end
         end
         2'b11: begin
            if (empty) begin
               op      = OP_ENQ;
               count_d = CW'(1);
            end else begin
               op = OP_REPL;
            end
         end
         default: ;
      endcase
   end

   for (genvar g = 0; g < QUEUE_SIZE; g++) begin : g_slot
      logic [KEY_WIDTH-1:0] prev_key, next_key;
      logic [VAL_WIDTH-1:0] prev_val, next_val;
      logic                 ge_prev;

      if (g == 0) begin : g_first
         assign prev_key = '0;
         assign prev_val = '0;
         assign ge_prev  = 1'b0;
      end else begin : g_mid
         assign prev_key = key_q[g-1];
         assign prev_val = val_q[g-1];
         assign ge_prev  = ge[g-1];
      end

      if (g == QUEUE_SIZE - 1) begin : g_last
         assign next_key = '0;
         assign next_val = '0;
      end else begin : g_inner
         assign next_key = key_q[g+1];
         assign next_val = val_q[g+1];
      end

      register_array_kv_cell #(
         .KEY_WIDTH (KEY_WIDTH),
         .VAL_WIDTH (VAL_WIDTH),
         .FIRST     (g == 0)
      ) u_cell (
         .own_key  (key_q[g]),
         .own_val  (val_q[g]),
         .prev_key (prev_key),
         .prev_val (prev_val),
         .next_key (next_key),
         .next_val (next_val),
         .new_key  (i_key),
         .new_val  (i_val),
         .op       (op),
         .ge_me    (ge[g]),
         .ge_prev  (ge_prev),
         .ge_next  (ge[g+1]),
         .key_d    (key_d[g]),
         .val_d    (val_d[g])
      );
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            key_q[i] <= '0;
            val_q[i] <= '0;
         end
         count_q <= '0;
         drop_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            key_q[i] <= key_d[i];
            val_q[i] <= val_d[i];
         end
         count_q <= count_d;
         drop_q  <= drop_d;
         err_q   <= err_d;
      end
   end

   assign o_key   = key_q[0];
   assign o_val   = val_q[0];
   assign o_count = count_q;
   assign o_full  = full;
   assign o_empty = empty;
   assign o_drop  = drop_q;
   assign o_err   = err_q;

endmodule
